// File: rtl/div_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// div_sequencer_pkg
// Shared encodings for the RV32M divide/remainder sequencer: FSM state codes,
// funct3/funct7/opcode constants and small helpers used by the sequencer.
// -----------------------------------------------------------------------------
package div_sequencer_pkg;

  localparam int XLEN = 32;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PREP = 3'd1,
    ST_ITER = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  localparam logic [2:0] FUNCT3_DIV  = 3'b100;
  localparam logic [2:0] FUNCT3_DIVU = 3'b101;
  localparam logic [2:0] FUNCT3_REM  = 3'b110;
  localparam logic [2:0] FUNCT3_REMU = 3'b111;

  localparam logic [6:0] OP_R_TYPE     = 7'b0110011;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  localparam logic [XLEN-1:0] SIGNED_MIN = {1'b1, {(XLEN-1){1'b0}}};

  function automatic logic is_signed_op(input logic [2:0] f3);
    return (f3 == FUNCT3_DIV) || (f3 == FUNCT3_REM);
  endfunction

  function automatic logic is_rem_op(input logic [2:0] f3);
    return (f3 == FUNCT3_REM) || (f3 == FUNCT3_REMU);
  endfunction

  // Two's complement negation when en is set.
  function automatic logic [XLEN-1:0] neg_if(input logic en, input logic [XLEN-1:0] v);
    return en ? (~v + XLEN'(1)) : v;
  endfunction

  // Architectural result for divide-by-zero (div_zero=1) or signed overflow.
  function automatic logic [XLEN-1:0] special_value(input logic [2:0] f3,
                                                    input logic [XLEN-1:0] a,
                                                    input logic div_zero);
    if (is_rem_op(f3)) return div_zero ? a : '0;
    else               return div_zero ? '1 : SIGNED_MIN;
  endfunction

endpackage

// File: rtl/div_step.sv
// -----------------------------------------------------------------------------
// div_step
// One combinational restoring-division step: shift {rem,quo} left by one,
// trial-subtract the divisor and set the new quotient bit when the difference
// is non-negative.
//   rem_in   33-bit partial remainder      quo_in  quotient / dividend shifter
//   divisor  unsigned divisor              rem_out, quo_out  next step values
// -----------------------------------------------------------------------------
module div_step
  import div_sequencer_pkg::*;
(
  input  logic [XLEN:0]   rem_in,
  input  logic [XLEN-1:0] quo_in,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN:0]   rem_out,
  output logic [XLEN-1:0] quo_out
);

  logic [XLEN:0]   shifted;
  logic [XLEN+1:0] diff;

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the block can leave a value unassigned and infer a latch.
  always_comb begin
    shifted = {rem_in[XLEN-1:0], quo_in[XLEN-1]};
    // Extra top bit carries the borrow of the trial subtraction.
    diff    = {rem_in[XLEN], shifted} - {2'b00, divisor};
    rem_out = diff[XLEN:0];
    quo_out = {quo_in[XLEN-2:0], 1'b1};
    if (diff[XLEN+1]) begin
      rem_out = shifted;
      quo_out = {quo_in[XLEN-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/div_sequencer.sv
// -----------------------------------------------------------------------------
// div_sequencer
// EX-stage sequencer for DIV/DIVU/REM/REMU. Runs a 32-step restoring divider,
// stalls the pipeline while working and pulses done with the result.
//   clk, reset (sync, active high)
//   start, funct3, op_a, op_b   operation request, captured in IDLE
//   flush                       abort to IDLE, no done
//   busy, stall, done, result   status, pipeline hold, result pulse / value
// Optional build macro DIV_ZERO_FAST_EN: divide-by-zero and signed overflow go
// from PREP straight to DONE (done two cycles after start).
// -----------------------------------------------------------------------------
module div_sequencer
  import div_sequencer_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            flush,
  output logic            busy,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] result
);

  state_e          state;
  logic [4:0]      count;
  logic            done_q;
  logic [XLEN-1:0] result_q;

  logic [2:0]      f3_q;
  logic [XLEN-1:0] a_q, b_q, divisor_q, quo_q;
  logic [XLEN:0]   rem_q;
  logic            q_neg_q, r_neg_q, div_zero_q, ovf_q;

  logic            a_sign, b_sign, pre_div_zero, pre_ovf;
  logic [XLEN-1:0] a_abs, b_abs, q_fix, r_fix, fix_val, step_quo;
  logic [XLEN:0]   step_rem;

  div_step u_step (
    .rem_in  (rem_q),
    .quo_in  (quo_q),
    .divisor (divisor_q),
    .rem_out (step_rem),
    .quo_out (step_quo)
  );

  always_comb begin
    a_sign       = is_signed_op(f3_q) & a_q[XLEN-1];
    b_sign       = is_signed_op(f3_q) & b_q[XLEN-1];
    a_abs        = neg_if(a_sign, a_q);
    b_abs        = neg_if(b_sign, b_q);
    pre_div_zero = (b_q == '0);
    pre_ovf      = is_signed_op(f3_q) && (a_q == SIGNED_MIN) && (b_q == '1);
    q_fix        = neg_if(q_neg_q, quo_q);
    r_fix        = neg_if(r_neg_q, rem_q[XLEN-1:0]);
    fix_val      = is_rem_op(f3_q) ? r_fix : q_fix;
    if (div_zero_q || ovf_q) fix_val = special_value(f3_q, a_q, div_zero_q);
  end

  // Control FSM with registered done/result.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      count    <= 5'd0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else if (flush) begin
      state  <= ST_IDLE;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: if (start) state <= ST_PREP;
        ST_PREP: begin
          count <= 5'd31;
`ifdef DIV_ZERO_FAST_EN
          if (pre_div_zero || pre_ovf) begin
            state    <= ST_DONE;
            done_q   <= 1'b1;
            result_q <= special_value(f3_q, a_q, pre_div_zero);
          end else begin
            state <= ST_ITER;
          end
`else
          state <= ST_ITER;
`endif
        end
        ST_ITER: begin
          // count saturates at zero; it is only reloaded in PREP.
          if (count == 5'd0) state <= ST_FIX;
          else               count <= count - 5'd1;
        end
        ST_FIX: begin
          state    <= ST_DONE;
          done_q   <= 1'b1;
          result_q <= fix_val;
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // NOTE: operand/datapath registers carry no reset; each is loaded in IDLE or
  // PREP before it is read, so a reset would only add fan-out.
  always_ff @(posedge clk) begin
    case (state)
      ST_IDLE: if (start && !flush) begin
        f3_q <= funct3;
        a_q  <= op_a;
        b_q  <= op_b;
      end
      ST_PREP: begin
        quo_q      <= a_abs;
        rem_q      <= '0;
        divisor_q  <= b_abs;
        q_neg_q    <= a_sign ^ b_sign;
        r_neg_q    <= a_sign;
        div_zero_q <= pre_div_zero;
        ovf_q      <= pre_ovf;
      end
      ST_ITER: begin
        quo_q <= step_quo;
        rem_q <= step_rem;
      end
      default: ;
    endcase
  end

  assign busy   = (state != ST_IDLE);
  assign stall  = ((state == ST_IDLE) && start && !flush) ||
                  (state == ST_PREP) || (state == ST_ITER) || (state == ST_FIX);
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_div_sequencer.sv
// -----------------------------------------------------------------------------
// tb_div_sequencer
// Directed bench for div_sequencer: reset state, unsigned/signed results and
// latency, divide-by-zero, overflow, flush, ignored start and mid-op reset.
// Build with +define+DIV_ZERO_FAST_EN to match the fast special-case build.
// -----------------------------------------------------------------------------
module tb_div_sequencer;
  import div_sequencer_pkg::*;

`ifdef DIV_ZERO_FAST_EN
  localparam int SPECIAL_LAT = 2;
`else
  localparam int SPECIAL_LAT = 35;
`endif

  logic        clk = 1'b0;
  logic        reset, start, flush;
  logic [2:0]  funct3;
  logic [31:0] op_a, op_b;
  logic        busy, stall, done;
  logic [31:0] result;

  int checks = 0;
  int passes = 0;

  typedef struct packed {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  div_sequencer dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .funct3 (funct3),
    .op_a   (op_a),
    .op_b   (op_b),
    .flush  (flush),
    .busy   (busy),
    .stall  (stall),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  // Issues one op in the current cycle (caller sits just after a negedge) and
  // follows it until done. Returns latency in cycles (-1 on timeout), the
  // result seen with done, and whether stall was high until done and low then.
  task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       output int lat, output logic [31:0] res, output bit stall_ok);
    start = 1'b1; funct3 = f3; op_a = a; op_b = b;
    #1 stall_ok = (stall === 1'b1);
    @(negedge clk);
    start = 1'b0;
    lat = -1;
    res = 'x;
    for (int c = 1; c <= 40; c++) begin
      if (done === 1'b1) begin
        lat = c;
        res = result;
        if (stall !== 1'b0) stall_ok = 1'b0;
        break;
      end
      if (stall !== 1'b1) stall_ok = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; flush = 1'b0; funct3 = 3'b000; op_a = '0; op_b = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, stall, done, result} !== 35'd0)
      $display("FAIL reset_state got busy=%b stall=%b done=%b result=%h want all 0",
               busy, stall, done, result);
    else passes++;
  endtask

  task automatic test_unsigned();
    vec_t v [4];
    int lat; logic [31:0] res; bit sok;
    v = '{'{FUNCT3_DIVU, 32'd100, 32'd7, 32'd14},
          '{FUNCT3_REMU, 32'd100, 32'd7, 32'd2},
          '{FUNCT3_DIVU, 32'hFFFFFFFF, 32'h80000001, 32'd1},
          '{FUNCT3_REMU, 32'hFFFFFFFF, 32'h80000001, 32'h7FFFFFFE}};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      do_op(v[i].f3, v[i].a, v[i].b, lat, res, sok);
      checks++;
      if (res !== v[i].exp) $display("FAIL unsigned[%0d] result got %h want %h", i, res, v[i].exp);
      else passes++;
      checks++;
      if (lat !== 35) $display("FAIL unsigned[%0d] latency got %0d want 35", i, lat);
      else passes++;
      checks++;
      if (sok !== 1'b1) $display("FAIL unsigned[%0d] stall_shape got %b want 1", i, sok);
      else passes++;
    end
  endtask

  task automatic test_signed();
    vec_t v [8];
    int lat; logic [31:0] res; bit sok;
    v = '{'{FUNCT3_DIV, 32'hFFFFFFEC, 32'd3, 32'hFFFFFFFA},
          '{FUNCT3_REM, 32'hFFFFFFEC, 32'd3, 32'hFFFFFFFE},
          '{FUNCT3_REM, 32'd20, 32'hFFFFFFFD, 32'd2},
          '{FUNCT3_DIV, 32'd20, 32'hFFFFFFFD, 32'hFFFFFFFA},
          '{FUNCT3_DIV, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'd3},
          '{FUNCT3_REM, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF},
          '{FUNCT3_DIV, 32'h80000000, 32'd1, 32'h80000000},
          '{FUNCT3_DIVU, 32'h80000000, 32'hFFFFFFFF, 32'd0}};
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      do_op(v[i].f3, v[i].a, v[i].b, lat, res, sok);
      checks++;
      if (res !== v[i].exp) $display("FAIL signed[%0d] result got %h want %h", i, res, v[i].exp);
      else passes++;
      checks++;
      if (lat !== 35) $display("FAIL signed[%0d] latency got %0d want 35", i, lat);
      else passes++;
    end
  endtask

  task automatic test_special();
    vec_t v [6];
    int lat; logic [31:0] res; bit sok;
    v = '{'{FUNCT3_DIVU, 32'h12345678, 32'd0, 32'hFFFFFFFF},
          '{FUNCT3_REMU, 32'h12345678, 32'd0, 32'h12345678},
          '{FUNCT3_DIV,  32'hFFFFFFFB, 32'd0, 32'hFFFFFFFF},
          '{FUNCT3_REM,  32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB},
          '{FUNCT3_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h80000000},
          '{FUNCT3_REM,  32'h80000000, 32'hFFFFFFFF, 32'd0}};
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      do_op(v[i].f3, v[i].a, v[i].b, lat, res, sok);
      checks++;
      if (res !== v[i].exp) $display("FAIL special[%0d] result got %h want %h", i, res, v[i].exp);
      else passes++;
      checks++;
      if (lat !== SPECIAL_LAT) $display("FAIL special[%0d] latency got %0d want %0d", i, lat, SPECIAL_LAT);
      else passes++;
      checks++;
      if (sok !== 1'b1) $display("FAIL special[%0d] stall_shape got %b want 1", i, sok);
      else passes++;
    end
  endtask

  task automatic test_flush();
    int lat; logic [31:0] res; bit sok;
    @(negedge clk);
    do_op(FUNCT3_DIVU, 32'd100, 32'd7, lat, res, sok);   // leaves result = 14
    @(negedge clk);
    start = 1'b1; funct3 = FUNCT3_DIVU; op_a = 32'd1000; op_b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);                          // 10th ITER cycle
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checks++;
    if ({busy, stall, done} !== 3'b000)
      $display("FAIL flush_idle got busy=%b stall=%b done=%b want 000", busy, stall, done);
    else passes++;
    checks++;
    if (result !== 32'd14) $display("FAIL flush_result_hold got %h want %h", result, 32'd14);
    else passes++;
    do_op(FUNCT3_DIVU, 32'd1000, 32'd3, lat, res, sok);  // start right after flush
    checks++;
    if (res !== 32'd333 || lat !== 35)
      $display("FAIL flush_restart got result=%h lat=%0d want result=%h lat=35", res, lat, 32'd333);
    else passes++;
    // flush and start together: flush wins
    @(negedge clk);
    start = 1'b1; flush = 1'b1; funct3 = FUNCT3_DIVU; op_a = 32'd5; op_b = 32'd1;
    #1;
    checks++;
    if (stall !== 1'b0) $display("FAIL flush_vs_start_stall got %b want 0", stall);
    else passes++;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    checks++;
    if (busy !== 1'b0) $display("FAIL flush_vs_start_busy got %b want 0", busy);
    else passes++;
  endtask

  task automatic test_start_ignored();
    int ndone = 0;
    logic [31:0] res = '0;
    @(negedge clk);
    start = 1'b1; funct3 = FUNCT3_DIVU; op_a = 32'd100; op_b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= 45; c++) begin
      if (c == 5) begin
        start = 1'b1; funct3 = FUNCT3_REMU; op_a = 32'd50; op_b = 32'd3;
      end else begin
        start = 1'b0;
      end
      if (done === 1'b1) begin
        ndone++;
        res = result;
      end
      @(negedge clk);
    end
    checks++;
    if (ndone !== 1) $display("FAIL start_ignored_done_count got %0d want 1", ndone);
    else passes++;
    checks++;
    if (res !== 32'd14) $display("FAIL start_ignored_result got %h want %h", res, 32'd14);
    else passes++;
  endtask

  task automatic test_reset_mid();
    int lat; logic [31:0] res; bit sok;
    @(negedge clk);
    start = 1'b1; funct3 = FUNCT3_DIVU; op_a = 32'd100; op_b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);                          // cycle N+20
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if ({busy, stall, done, result} !== 35'd0)
      $display("FAIL reset_mid got busy=%b stall=%b done=%b result=%h want all 0",
               busy, stall, done, result);
    else passes++;
    do_op(FUNCT3_DIVU, 32'd9, 32'd2, lat, res, sok);
    checks++;
    if (res !== 32'd4 || lat !== 35)
      $display("FAIL reset_recover got result=%h lat=%0d want result=%h lat=35", res, lat, 32'd4);
    else passes++;
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_special();
    test_flush();
    test_start_ignored();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
